// File: rtl/dpram_port_sequencer_if.sv
// dpram_port_sequencer_if
//   Bundles the two logical RAM ports (A and B), the slot indicator and the
//   single-port SRAM macro connection of dpram_port_sequencer.
//   slave  : the sequencer side (takes requests, drives grants, read returns
//            and the macro strobes; takes macro read data).
//   master : the requester/macro side (drives requests and macro read data).
interface dpram_port_sequencer_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  // Port A
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic          a_rvalid;
  logic [DW-1:0] a_rdata;
  // Port B
  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt;
  logic          b_rvalid;
  logic [DW-1:0] b_rdata;
  // Slot owner and macro side
  logic          slot;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  ram_rdata,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output slot, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output ram_rdata,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  slot, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/dpram_port_sequencer.sv
// dpram_port_sequencer
//   Runs on the doubled clock and serves two logical RAM ports (A, B) from one
//   single-port SRAM macro by alternating slots, so each port gets one access
//   per base-clock cycle. Reads come back on the issuing port, tagged through a
//   RAM_LAT-deep pipeline that tracks the macro read latency.
// Ports:
//   clk    doubled clock, rising edge only
//   rst_n  asynchronous active-low reset
//   align  forces the next cycle to be slot A
//   bus    dpram_port_sequencer_if.slave: A/B req/we/addr/wdata in, gnt,
//          rvalid, rdata out; slot out; ram_en/we/addr/wdata out; ram_rdata in
// Parameters:
//   AW, DW           address / data width
//   RAM_LAT          macro read latency (1..4) from ram_en to ram_rdata valid
//   WORK_CONSERVING  1 lets an idle slot be lent to the other port
// Grant to rvalid is RAM_LAT+2 cycles: one to register the macro drive,
// RAM_LAT in the macro, one to register the returned data.
module dpram_port_sequencer #(
  parameter int AW              = 8,
  parameter int DW              = 32,
  parameter int RAM_LAT         = 1,
  parameter int WORK_CONSERVING = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  input logic                   align,
  dpram_port_sequencer_if.slave bus
);

  localparam logic WC = (WORK_CONSERVING != 0) ? 1'b1 : 1'b0;

  logic               slot_q,      slot_d;
  logic               ram_en_q,    ram_en_d;
  logic               ram_we_q,    ram_we_d;
  logic               ram_port_q,  ram_port_d;
  logic [AW-1:0]      ram_addr_q,  ram_addr_d;
  logic [DW-1:0]      ram_wdata_q, ram_wdata_d;
  logic [RAM_LAT-1:0] tag_vld_q,   tag_vld_d;
  logic [RAM_LAT-1:0] tag_prt_q,   tag_prt_d;
  logic               a_rvalid_q,  a_rvalid_d;
  logic               b_rvalid_q,  b_rvalid_d;
  logic [DW-1:0]      a_rdata_q,   a_rdata_d;
  logic [DW-1:0]      b_rdata_q,   b_rdata_d;
  logic               a_gnt_s,     b_gnt_s;

  // Grant arbitration: slot owner wins; an idle slot may be lent out.
  always_comb begin
    a_gnt_s = bus.a_req & (~slot_q | (WC & slot_q & ~bus.b_req));
    b_gnt_s = bus.b_req & (slot_q | (WC & ~slot_q & ~bus.a_req));
  end

  // Next-state: slot counter, macro drive, read-tag pipeline, read return.
  always_comb begin
    if (align) begin
      slot_d = 1'b0;
    end else begin
      slot_d = ~slot_q;
    end

    if (a_gnt_s) begin
      ram_en_d    = 1'b1;
      ram_we_d    = bus.a_we;
      ram_port_d  = 1'b0;
      ram_addr_d  = bus.a_addr;
      ram_wdata_d = bus.a_wdata;
    end else if (b_gnt_s) begin
      ram_en_d    = 1'b1;
      ram_we_d    = bus.b_we;
      ram_port_d  = 1'b1;
      ram_addr_d  = bus.b_addr;
      ram_wdata_d = bus.b_wdata;
    end else begin
      // Idle: strobes drop, address/data/port hold to avoid macro pin toggling.
      ram_en_d    = 1'b0;
      ram_we_d    = 1'b0;
      ram_port_d  = ram_port_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
    end

    // The tag enters alongside the macro access and leaves the pipeline in the
    // same cycle the macro presents the read data.
    tag_vld_d    = tag_vld_q;
    tag_prt_d    = tag_prt_q;
    tag_vld_d[0] = ram_en_q & ~ram_we_q;
    tag_prt_d[0] = ram_port_q;
    for (int i = 1; i < RAM_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_prt_d[i] = tag_prt_q[i-1];
    end

    a_rvalid_d = tag_vld_q[RAM_LAT-1] & ~tag_prt_q[RAM_LAT-1];
    b_rvalid_d = tag_vld_q[RAM_LAT-1] &  tag_prt_q[RAM_LAT-1];

    if (a_rvalid_d) begin
      a_rdata_d = bus.ram_rdata;
    end else begin
      a_rdata_d = a_rdata_q;
    end
    if (b_rvalid_d) begin
      b_rdata_d = bus.ram_rdata;
    end else begin
      b_rdata_d = b_rdata_q;
    end
  end

  // State registers; reset discards every outstanding read tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q      <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_port_q  <= 1'b0;
      ram_addr_q  <= {AW{1'b0}};
      ram_wdata_q <= {DW{1'b0}};
      tag_vld_q   <= {RAM_LAT{1'b0}};
      tag_prt_q   <= {RAM_LAT{1'b0}};
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_rdata_q   <= {DW{1'b0}};
      b_rdata_q   <= {DW{1'b0}};
    end else begin
      slot_q      <= slot_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_port_q  <= ram_port_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      tag_vld_q   <= tag_vld_d;
      tag_prt_q   <= tag_prt_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

  assign bus.a_gnt     = a_gnt_s;
  assign bus.b_gnt     = b_gnt_s;
  assign bus.a_rvalid  = a_rvalid_q;
  assign bus.b_rvalid  = b_rvalid_q;
  assign bus.a_rdata   = a_rdata_q;
  assign bus.b_rdata   = b_rdata_q;
  assign bus.slot      = slot_q;
  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_dpram_port_sequencer.sv
// Bench for dpram_port_sequencer. Two instances: inst0 (RAM_LAT=1,
// WORK_CONSERVING=1) and inst1 (RAM_LAT=3, WORK_CONSERVING=0), each with a
// behavioural macro. A per-cycle model checks slot/grant/macro drive, and a
// scoreboard of expected read returns is filled at grant time.
module tb_dpram_port_sequencer;

  localparam int AW = 8;
  localparam int DW = 32;

  typedef struct {
    int          inst;
    int          port;
    logic [31:0] data;
    int          cyc;
  } sb_t;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } op_t;

  typedef struct {
    logic al, a, b;
    logic exp_slot;
    logic ag0, bg0, ag1, bg1;
  } vec_t;

  logic clk;
  logic rst_n;
  logic [1:0] align_s, a_req_s, a_we_s, b_req_s, b_we_s;
  logic [AW-1:0] a_addr_s [2];
  logic [AW-1:0] b_addr_s [2];
  logic [DW-1:0] a_wdata_s [2];
  logic [DW-1:0] b_wdata_s [2];

  logic [1:0] a_gnt_w, b_gnt_w, a_rvalid_w, b_rvalid_w, slot_w, ram_en_w, ram_we_w;
  logic [DW-1:0] a_rdata_w [2];
  logic [DW-1:0] b_rdata_w [2];
  logic [DW-1:0] ram_wdata_w [2];
  logic [AW-1:0] ram_addr_w [2];

  int checks;
  int failures;
  int cyc;
  sb_t sb [$];
  op_t opa [16];
  op_t opb [16];
  vec_t vecs [11];

  // reference model state
  logic [1:0]    slot_m, en_m, we_m;
  logic [AW-1:0] addr_m [2];
  logic [DW-1:0] wd_m [2];
  logic [DW-1:0] rd_m [2][2];
  logic [DW-1:0] ref_mem [2][256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    localparam int W = (g == 0) ? 1 : 0;
    dpram_port_sequencer_if #(.AW(AW), .DW(DW)) bus ();
    logic [DW-1:0] mem [256];
    logic [DW-1:0] pipe [L];

    assign bus.a_req   = a_req_s[g];
    assign bus.a_we    = a_we_s[g];
    assign bus.a_addr  = a_addr_s[g];
    assign bus.a_wdata = a_wdata_s[g];
    assign bus.b_req   = b_req_s[g];
    assign bus.b_we    = b_we_s[g];
    assign bus.b_addr  = b_addr_s[g];
    assign bus.b_wdata = b_wdata_s[g];
    assign bus.ram_rdata = pipe[L-1];

    assign a_gnt_w[g]     = bus.a_gnt;
    assign b_gnt_w[g]     = bus.b_gnt;
    assign a_rvalid_w[g]  = bus.a_rvalid;
    assign b_rvalid_w[g]  = bus.b_rvalid;
    assign a_rdata_w[g]   = bus.a_rdata;
    assign b_rdata_w[g]   = bus.b_rdata;
    assign slot_w[g]      = bus.slot;
    assign ram_en_w[g]    = bus.ram_en;
    assign ram_we_w[g]    = bus.ram_we;
    assign ram_addr_w[g]  = bus.ram_addr;
    assign ram_wdata_w[g] = bus.ram_wdata;

    dpram_port_sequencer #(.AW(AW), .DW(DW), .RAM_LAT(L), .WORK_CONSERVING(W)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .align (align_s[g]),
      .bus   (bus)
    );

    // Behavioural macro: preloaded with addr*0x10 while in reset, L-cycle read.
    always @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < 256; i++) mem[i] <= 32'(i * 16);
        for (int k = 0; k < L; k++) pipe[k] <= 32'h0;
      end else begin
        if (bus.ram_en && bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        pipe[0] <= (bus.ram_en && !bus.ram_we) ? mem[bus.ram_addr] : 32'hDEADBEEF;
        for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
      end
    end
  end

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d: got 0x%0h want 0x%0h (t=%0t)", nm, inst, act, exp, $time);
    end
  endtask

  task automatic check_ret(input int i, input int p, input logic v);
    int idx;
    if (v) begin
      idx = -1;
      for (int k = 0; k < sb.size(); k++) begin
        if (sb[k].inst == i && sb[k].port == p) begin
          idx = k;
          break;
        end
      end
      chk(p == 0 ? "a_rvalid_expected" : "b_rvalid_expected", i, 32'(idx >= 0), 32'd1);
      if (idx >= 0) begin
        chk(p == 0 ? "a_rvalid_latency" : "b_rvalid_latency", i,
            32'(cyc - sb[idx].cyc), 32'((i == 0 ? 1 : 3) + 2));
        rd_m[i][p] = sb[idx].data;
        sb.delete(idx);
      end
    end
  endtask

  // Per-cycle model check, sampled on the falling edge.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        slot_m = 2'b00; en_m = 2'b00; we_m = 2'b00;
        for (int i = 0; i < 2; i++) begin
          addr_m[i] = '0; wd_m[i] = '0; rd_m[i][0] = '0; rd_m[i][1] = '0;
          for (int j = 0; j < 256; j++) ref_mem[i][j] = 32'(j * 16);
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          logic ga, gb, wc;
          wc = (i == 0);
          ga = a_req_s[i] & (~slot_m[i] | (wc & slot_m[i] & ~b_req_s[i]));
          gb = b_req_s[i] & (slot_m[i] | (wc & ~slot_m[i] & ~a_req_s[i]));
          chk("slot", i, 32'(slot_w[i]), 32'(slot_m[i]));
          chk("a_gnt", i, 32'(a_gnt_w[i]), 32'(ga));
          chk("b_gnt", i, 32'(b_gnt_w[i]), 32'(gb));
          chk("ram_en", i, 32'(ram_en_w[i]), 32'(en_m[i]));
          chk("ram_we", i, 32'(ram_we_w[i]), 32'(we_m[i]));
          chk("ram_addr", i, 32'(ram_addr_w[i]), 32'(addr_m[i]));
          chk("ram_wdata", i, ram_wdata_w[i], wd_m[i]);
          check_ret(i, 0, a_rvalid_w[i]);
          check_ret(i, 1, b_rvalid_w[i]);
          chk("a_rdata", i, a_rdata_w[i], rd_m[i][0]);
          chk("b_rdata", i, b_rdata_w[i], rd_m[i][1]);
          if (ga) begin
            if (a_we_s[i]) ref_mem[i][a_addr_s[i]] = a_wdata_s[i];
            else sb.push_back('{i, 0, ref_mem[i][a_addr_s[i]], cyc});
            we_m[i] = a_we_s[i]; addr_m[i] = a_addr_s[i]; wd_m[i] = a_wdata_s[i];
          end else if (gb) begin
            if (b_we_s[i]) ref_mem[i][b_addr_s[i]] = b_wdata_s[i];
            else sb.push_back('{i, 1, ref_mem[i][b_addr_s[i]], cyc});
            we_m[i] = b_we_s[i]; addr_m[i] = b_addr_s[i]; wd_m[i] = b_wdata_s[i];
          end else begin
            we_m[i] = 1'b0;
          end
          en_m[i] = ga | gb;
          slot_m[i] = align_s[i] ? 1'b0 : ~slot_m[i];
        end
      end
      cyc++;
    end
  endtask

  // Pulse align on the masked instances; returns in a slot-0 cycle.
  task automatic do_align(input logic [1:0] m);
    align_s = m;
    @(posedge clk); #1;
    align_s = 2'b00;
  endtask

  task automatic run_ops(input int inst, input int na, input int nb, input int align_at, output int ncyc);
    int ia, ib;
    ia = 0; ib = 0; ncyc = 0;
    while ((ia < na || ib < nb) && ncyc < 200) begin
      a_req_s[inst] = (ia < na);
      if (ia < na) begin
        a_we_s[inst] = opa[ia].we; a_addr_s[inst] = opa[ia].addr; a_wdata_s[inst] = opa[ia].wdata;
      end
      b_req_s[inst] = (ib < nb);
      if (ib < nb) begin
        b_we_s[inst] = opb[ib].we; b_addr_s[inst] = opb[ib].addr; b_wdata_s[inst] = opb[ib].wdata;
      end
      align_s[inst] = (ncyc == align_at);
      @(negedge clk);
      if (align_at >= 0 && ncyc == align_at + 1) chk("slot_after_align", inst, 32'(slot_w[inst]), 32'd0);
      if (a_req_s[inst] && a_gnt_w[inst]) ia++;
      if (b_req_s[inst] && b_gnt_w[inst]) ib++;
      ncyc++;
      @(posedge clk); #1;
    end
    a_req_s[inst] = 1'b0; b_req_s[inst] = 1'b0; align_s[inst] = 1'b0;
    chk("run_ops_complete", inst, 32'(ia == na && ib == nb), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 0, 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int ncyc;
    clk = 1'b0; rst_n = 1'b0; checks = 0; failures = 0; cyc = 0;
    align_s = '0; a_req_s = '0; a_we_s = '0; b_req_s = '0; b_we_s = '0;
    for (int i = 0; i < 2; i++) begin
      a_addr_s[i] = '0; b_addr_s[i] = '0; a_wdata_s[i] = '0; b_wdata_s[i] = '0;
    end
    //         al    a     b     slot  ag0   bg0   ag1   bg1
    vecs = '{'{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0},
             '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
             '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
             '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1},
             '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0},
             '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0},
             '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1},
             '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
             '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1},
             '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
             '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_slot", i, 32'(slot_w[i]), 32'd0);
      chk("rst_gnt", i, 32'({a_gnt_w[i], b_gnt_w[i]}), 32'd0);
      chk("rst_rvalid", i, 32'({a_rvalid_w[i], b_rvalid_w[i]}), 32'd0);
      chk("rst_ram_en_we", i, 32'({ram_en_w[i], ram_we_w[i]}), 32'd0);
      chk("rst_ram_addr", i, 32'(ram_addr_w[i]), 32'd0);
      chk("rst_ram_wdata", i, ram_wdata_w[i], 32'd0);
      chk("rst_a_rdata", i, a_rdata_w[i], 32'd0);
      chk("rst_b_rdata", i, b_rdata_w[i], 32'd0);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Idle after release: slot 0,1,0,1 with nothing issued
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("idle_slot_seq", 0, 32'(slot_w[0]), 32'(k % 2));
      chk("idle_ram_en", 0, 32'(ram_en_w[0]), 32'd0);
    end
    @(posedge clk); #1;

    // Grant table, both instances driven together (inst1 does not lend slots)
    do_align(2'b11);
    for (int v = 0; v < 11; v++) begin
      a_req_s = {2{vecs[v].a}}; b_req_s = {2{vecs[v].b}}; align_s = {2{vecs[v].al}};
      a_we_s = '0; b_we_s = '0;
      for (int i = 0; i < 2; i++) begin a_addr_s[i] = 8'd5; b_addr_s[i] = 8'd6; end
      @(negedge clk);
      chk("vec_slot", 0, 32'(slot_w[0]), 32'(vecs[v].exp_slot));
      chk("vec_slot", 1, 32'(slot_w[1]), 32'(vecs[v].exp_slot));
      chk("vec_a_gnt", 0, 32'(a_gnt_w[0]), 32'(vecs[v].ag0));
      chk("vec_b_gnt", 0, 32'(b_gnt_w[0]), 32'(vecs[v].bg0));
      chk("vec_a_gnt", 1, 32'(a_gnt_w[1]), 32'(vecs[v].ag1));
      chk("vec_b_gnt", 1, 32'(b_gnt_w[1]), 32'(vecs[v].bg1));
      @(posedge clk); #1;
    end
    a_req_s = '0; b_req_s = '0; align_s = '0;
    drain();

    // Only A reads 0..7: work-conserving grants every cycle, otherwise every other
    for (int k = 0; k < 8; k++) opa[k] = '{1'b0, 8'(k), 32'h0};
    do_align(2'b01);
    run_ops(0, 8, 0, -1, ncyc);
    chk("wc1_cycles", 0, 32'(ncyc), 32'd8);
    drain();
    do_align(2'b10);
    run_ops(1, 8, 0, -1, ncyc);
    chk("wc0_cycles", 1, 32'(ncyc), 32'd15);
    drain();

    // A writes 0x11111111 to addr 3 while B reads addr 3, both continuous
    for (int k = 0; k < 4; k++) begin
      opa[k] = '{1'b1, 8'd3, 32'h11111111};
      opb[k] = '{1'b0, 8'd3, 32'h0};
    end
    do_align(2'b01);
    run_ops(0, 4, 4, -1, ncyc);
    chk("wr_rd_cycles", 0, 32'(ncyc), 32'd8);
    drain();

    // RAM_LAT=3, alternating A/B reads
    for (int k = 0; k < 4; k++) begin
      opa[k] = '{1'b0, 8'(k), 32'h0};
      opb[k] = '{1'b0, 8'(k + 4), 32'h0};
    end
    do_align(2'b10);
    run_ops(1, 4, 4, -1, ncyc);
    chk("lat3_cycles", 1, 32'(ncyc), 32'd8);
    drain();

    // align pulse in a slot-0 cycle with reads outstanding
    do_align(2'b01);
    run_ops(0, 4, 4, 2, ncyc);
    drain();

    // Reset with two reads in flight
    a_req_s[0] = 1'b1; a_we_s[0] = 1'b0; a_addr_s[0] = 8'd1;
    @(posedge clk); #1;
    a_addr_s[0] = 8'd2;
    @(posedge clk); #1;
    a_req_s[0] = 1'b0;
    #1;
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    chk("post_rst_slot", 0, 32'(slot_w[0]), 32'd0);
    chk("post_rst_ram_en", 0, 32'(ram_en_w[0]), 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("post_rst_no_rvalid", 0, 32'({a_rvalid_w[0], b_rvalid_w[0]}), 32'd0);
    end
    chk("final_sb_empty", 0, 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dpram_port_sequencer.md
Name: dpram_port_sequencer

Overview:
- Sits on the doubled clock and serves two logical RAM ports, A and B, from one single-port SRAM macro.
- The two ports are time-multiplexed into alternating slots, so each port sees one access per base-clock cycle.
- Each port uses a req/gnt handshake and gets back a tagged read-data return.
- This is the consumer end of the clock-doubling scheme: it turns the doubled clock back into two independent base-rate port streams.

Parameters:
- AW, 8, address width in bits.
- DW, 32, data width in bits.
- RAM_LAT, 1, macro read latency in cycles from ram_en to ram_rdata valid; legal range 1..4.
- WORK_CONSERVING, 1, when 1 an idle slot may be lent to the other port.

Ports:
- clk  input  1  doubled clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- align  input  1  slot realignment; when high, the next cycle is slot A.
- a_req  input  1  port A request.
- a_we  input  1  port A write enable (1 = write).
- a_addr  input  AW  port A address.
- a_wdata  input  DW  port A write data.
- a_gnt  output  1  port A request accepted this cycle.
- a_rvalid  output  1  port A read data valid.
- a_rdata  output  DW  port A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as port A, for port B.
- slot  output  1  current slot owner; 0 = A, 1 = B.
- ram_en  output  1  macro access strobe.
- ram_we  output  1  macro write enable.
- ram_addr  output  AW  macro address.
- ram_wdata  output  DW  macro write data.
- ram_rdata  input  DW  macro read data.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - slot=0.
  - a_gnt, b_gnt, a_rvalid, b_rvalid, ram_en, ram_we = 0.
  - ram_addr, ram_wdata, a_rdata, b_rdata = 0.
  - Return pipeline cleared.
- Slot counter: slot toggles every cycle. If align=1, slot is 0 in the following cycle regardless of its current value.
- Grant logic (combinational from the registered slot and the req inputs):
  - a_gnt = a_req & (slot==0 | (WORK_CONSERVING & slot==1 & !b_req)).
  - b_gnt = b_req & (slot==1 | (WORK_CONSERVING & slot==0 & !a_req)).
  - At most one grant per cycle. The slot owner always wins when both ports request.
- A request completes in the cycle where req=1 and gnt=1. The requester holds addr/we/wdata stable until gnt is seen.
- Macro drive (registered, one cycle after grant):
  - ram_en=1.
  - ram_we, ram_addr, ram_wdata copied from the granted port.
  - With no grant: ram_en=0, ram_we=0, and address/data hold their previous values.
- Read return:
  - Each read issued to the macro pushes a 2-bit tag {valid, port} into a RAM_LAT-deep shift register.
  - When a tag emerges, the owning port's rvalid pulses for 1 cycle and its rdata is registered from ram_rdata.
  - Total read latency from grant to rvalid is RAM_LAT+2 cycles.
  - The non-owning port's rdata holds its last value.
- Writes produce no rvalid.
- Back-to-back grants are allowed every cycle; there is no throughput limit beyond one access per cycle.
- Same-address write then read across slots: the read observes the new data, because the macro is accessed in order.
- align pulse mid-stream: the slot sequence restarts at A. In-flight reads still return to their tagged port; nothing is dropped or duplicated.
- Reset asserted mid-operation: all outstanding tags are discarded and no rvalid follows reset release.
- No combinational path from ram_rdata to any output.

Test Plan:
- Reset release, no requests -> slot toggles 0,1,0,1; ram_en, gnt and rvalid stay 0.
- a_req=1 and b_req=1 continuous; A writes 0x11111111 to addr 3, B reads addr 3; RAM_LAT=1:
  - a_gnt only in slot-0 cycles, b_gnt only in slot-1 cycles.
  - B's first b_rvalid arrives 3 cycles after its grant with 0x11111111.
  - ram_en stays high every cycle.
- WORK_CONSERVING=1, only A requesting, reads addr 0..7 (preloaded with addr*0x10):
  - a_gnt every cycle.
  - 8 consecutive a_rvalid pulses with data 0x00..0x70 in order.
  - Repeat with WORK_CONSERVING=0: a_gnt only every other cycle.
- RAM_LAT=3, alternating A and B reads -> each rvalid arrives 5 cycles after its own grant, on the correct port, with no cross-port leakage.
- align pulse while slot=0 and reads are outstanding -> slot=0 on the next cycle; all outstanding reads return once, to their tagged ports.
- rst_n low for 1 cycle with 2 reads in flight -> no rvalid after release; slot=0 and ram_en=0 on the first post-reset cycle.
